// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared definitions for the registered full adder.
//   FA_MAX_WIDTH : largest supported operand width.
//   fa_result_t  : container wide enough for a maximum-width {carry, sum} result.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    typedef logic [FA_MAX_WIDTH:0] fa_result_t;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit combinational full adder, the leaf of the ripple chain.
// Ports:
//   a, b  : operand bits
//   cin   : carry in from the next lower bit
//   s     : sum bit
//   cout  : carry out to the next higher bit
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder, {Co,S} = X + Y + Ci.
// Optional build macro FULL_ADDER_IN_REG_EN adds an input register stage
// (latency 2 instead of 1); function is otherwise identical.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : X/Y/Ci carry a real operation this cycle
//   X, Y, Ci   : operands and carry-in
//   S, Co      : registered sum and carry-out
//   out_valid  : S/Co hold the result of a valid operation
// Handshake: valid-only, no ready. An operation is accepted on every rising
// edge where in_valid=1 and rst_n=1; its result is presented exactly one
// latency later with out_valid=1 for one cycle. There is no backpressure.
// S/Co also update on invalid cycles; that data is deterministic but unused.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             out_valid
);

    // Operands as seen by the adder (registered or straight from the ports).
    logic [WIDTH-1:0] x_a;
    logic [WIDTH-1:0] y_a;
    logic             ci_a;
    logic             valid_a;

`ifdef FULL_ADDER_IN_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_a     <= '0;
            y_a     <= '0;
            ci_a    <= 1'b0;
            valid_a <= 1'b0;
        end else begin
            x_a     <= X;
            y_a     <= Y;
            ci_a    <= Ci;
            valid_a <= in_valid;
        end
    end
`else
    assign x_a     = X;
    assign y_a     = Y;
    assign ci_a    = Ci;
    assign valid_a = in_valid;
`endif

    // Ripple chain: carry[0] is the carry-in, carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = ci_a;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a    (x_a[i]),
            .b    (y_a[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    // Output stage: data loads every cycle; valid tracks the operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S         <= '0;
            Co        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            S         <= sum;
            Co        <= carry[WIDTH];
            out_valid <= valid_a;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized scoreboard bench for full_adder at WIDTH = 1, 8, 16.
// All three instances share clock, reset and in_valid; each has its own data.
module tb_full_adder;

`ifdef FULL_ADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic        x1, y1, ci1, s1, co1, ov1;
    logic [7:0]  x8, y8, s8;
    logic        ci8, co8, ov8;
    logic [15:0] x16, y16, s16;
    logic        ci16, co16, ov16;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .X(x1), .Y(y1), .Ci(ci1), .S(s1), .Co(co1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .X(x8), .Y(y8), .Ci(ci8), .S(s8), .Co(co8), .out_valid(ov8)
    );
    full_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .X(x16), .Y(y16), .Ci(ci16), .S(s16), .Co(co16), .out_valid(ov16)
    );

    // ---------------- scoreboard ----------------
    logic [1:0]  exp1_q[$];
    logic [8:0]  exp8_q[$];
    logic [16:0] exp16_q[$];
    int          cyc1_q[$];
    int          cyc8_q[$];
    int          cyc16_q[$];

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: plain unsigned addition one bit wider than the operands.
    task automatic push_expected();
        logic [1:0]  e1;
        logic [8:0]  e8;
        logic [16:0] e16;
        e1  = x1 + y1 + ci1;
        e8  = x8 + y8 + ci8;
        e16 = x16 + y16 + ci16;
        exp1_q.push_back(e1);
        exp8_q.push_back(e8);
        exp16_q.push_back(e16);
        cyc1_q.push_back(cyc + LAT);
        cyc8_q.push_back(cyc + LAT);
        cyc16_q.push_back(cyc + LAT);
    endtask

    // Monitor: every presented result must match the oldest expected one,
    // at exactly the build's latency.
    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (exp1_q.size() == 0) chk("w1 unexpected valid", 64'd1, 64'd0);
            else begin
                chk("w1 result", 64'({co1, s1}), 64'(exp1_q.pop_front()));
                chk("w1 latency", 64'(cyc), 64'(cyc1_q.pop_front()));
            end
        end
        if (ov8 === 1'b1) begin
            if (exp8_q.size() == 0) chk("w8 unexpected valid", 64'd1, 64'd0);
            else begin
                chk("w8 result", 64'({co8, s8}), 64'(exp8_q.pop_front()));
                chk("w8 latency", 64'(cyc), 64'(cyc8_q.pop_front()));
            end
        end
        if (ov16 === 1'b1) begin
            if (exp16_q.size() == 0) chk("w16 unexpected valid", 64'd1, 64'd0);
            else begin
                chk("w16 result", 64'({co16, s16}), 64'(exp16_q.pop_front()));
                chk("w16 latency", 64'(cyc), 64'(cyc16_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        if (rst_n && in_valid) push_expected();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(logic v, logic [15:0] x, logic [15:0] y, logic ci);
        in_valid = v;
        x1 = x[0];  y1 = y[0];  ci1 = ci;
        x8 = x[7:0]; y8 = y[7:0]; ci8 = ci;
        x16 = x;    y16 = y;    ci16 = ci;
    endtask

    task automatic check_cleared(string tag);
        chk({tag, " w1 outputs"},  64'({ov1, co1, s1}), 64'd0);
        chk({tag, " w8 outputs"},  64'({ov8, co8, s8}), 64'd0);
        chk({tag, " w16 outputs"}, 64'({ov16, co16, s16}), 64'd0);
    endtask

    // Hold reset for n edges; anything not yet reported is discarded.
    task automatic do_reset(int n, string tag);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            exp1_q.delete();  exp8_q.delete();  exp16_q.delete();
            cyc1_q.delete();  cyc8_q.delete();  cyc16_q.delete();
            check_cleared(tag);
        end
        rst_n = 1'b1;
    endtask

    task automatic drain();
        set_all(1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        chk("drain queues empty",
            64'(exp1_q.size() + exp8_q.size() + exp16_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_all(1'b0, 16'h0, 16'h0, 1'b0);

        // Power-on reset.
        do_reset(2, "por");

        // Truth table: {X,Y,Ci} = 000..111 on every width.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            set_all(1'b1, {15'd0, v[2]}, {15'd0, v[1]}, v[0]);
            tick();
        end

        // Boundaries.
        set_all(1'b1, 16'h00FF, 16'h0000, 1'b1); tick();
        set_all(1'b1, 16'hFFFF, 16'hFFFF, 1'b1); tick();
        set_all(1'b1, 16'h0000, 16'h0000, 1'b0); tick();
        set_all(1'b1, 16'hFFFF, 16'h0001, 1'b0); tick();
        drain();

        // Reset held 3 cycles with live-looking inputs.
        set_all(1'b1, 16'h0001, 16'h0001, 1'b0);
        do_reset(3, "reset hold");
        tick();
        drain();

        // Reset one cycle after a valid operation.
        set_all(1'b1, 16'h1234, 16'h4321, 1'b1); tick();
        set_all(1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
        do_reset(2, "midstream");
        drain();

        // in_valid toggling 1,0,1.
        set_all(1'b1, 16'h0003, 16'h0005, 1'b0); tick();
        set_all(1'b0, 16'hAAAA, 16'h5555, 1'b1); tick();
        set_all(1'b1, 16'h8000, 16'h8000, 1'b1); tick();
        drain();

        // Random vectors, mostly valid.
        for (int i = 0; i < 1000; i++) begin
            set_all($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)));
            x1 = 1'($urandom_range(0, 1));
            y1 = 1'($urandom_range(0, 1));
            x8 = 8'($urandom);
            y8 = 8'($urandom);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1);
    end

endmodule
